// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter: ALU results vs. FIFO-buffered memory results
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wd,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  // FIFO storage is not reset: only entries covered by the pointers are ever read
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_wa_q, rf_wa_d;
  logic [31:0]   rf_wd_q, rf_wd_d;

  logic fifo_ne;
  logic force_fifo;
  logic alu_win;
  logic pop;
  logic push;

  // Arbitration uses registered occupancy only, so an entry pushed this cycle
  // cannot be popped until the next one and a pop never frees room early.
  always_comb begin
    fifo_ne    = (cnt_q != '0);
    force_fifo = fifo_ne && (starve_q == SW'(STARVE_MAX));
    alu_ready  = !force_fifo;
    mem_ready  = (cnt_q != CW'(DEPTH));
    alu_win    = alu_valid && !force_fifo;
    pop        = force_fifo || (!alu_valid && fifo_ne);
    push       = mem_valid && mem_ready && (mem_rd != 5'd0);
  end

  // Next-state for pointers, occupancy, starvation counter and writeback port
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    rf_we_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end

    if (pop) begin
      rf_we_d = 1'b1;
      rf_wa_d = rd_mem_q[rd_ptr_q];
      rf_wd_d = data_mem_q[rd_ptr_q];
    end else if (alu_win && (alu_rd != 5'd0)) begin
      rf_we_d = 1'b1;
      rf_wa_d = alu_rd;
      rf_wd_d = alu_data;
    end
  end

  // FIFO entry write at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= mem_rd;
      data_mem_q[wr_ptr_q] <= mem_data;
    end
  end

  // Control and writeback registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scoreboard bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [2:0]  pend_cnt;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   alu_idx;

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then inspect the writeback port against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rf_we === 1'b1) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rf_wa", 32'(rf_wa), 32'(e.wa));
        chk("rf_wd", rf_wd, e.wd);
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("missing_write", 32'(rf_we), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic set_alu(input int idx);
    alu_valid = 1'b1;
    alu_rd    = 5'(10 + idx);
    alu_data  = 32'hA000_0000 + 32'(idx);
  endtask

  task automatic push_alu_exp();
    exp_t e;
    e.wa = alu_rd; e.wd = alu_data; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic push_exp(input logic [4:0] wa, input logic [31:0] wd, input int at);
    exp_t e;
    e.wa = wa; e.wd = wd; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    checks = 0; errors = 0; cyc = 0; alu_idx = 0;
    idle_inputs();
    tick();
    tick();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // ALU-only write with one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    chk("alu_ready_offer", 32'(alu_ready), 32'd1);
    push_alu_exp();
    tick();
    chk("alu_ready_after", 32'(alu_ready), 32'd1);
    alu_valid = 1'b0;
    tick();
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_rf_wa_hold", 32'(rf_wa), 32'd5);
    chk("idle_rf_wd_hold", rf_wd, 32'h0000_00AA);

    // ALU result to x0 produces no write
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    chk("alu_x0_rf_we", 32'(rf_we), 32'd0);
    alu_valid = 1'b0;

    // Memory result to x0 accepted and dropped
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h123;
    chk("x0_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("x0_pend_cnt", 32'(pend_cnt), 32'd0);
    mem_valid = 1'b0;
    tick();
    tick();
    chk("x0_rf_we", 32'(rf_we), 32'd0);

    // Fill the FIFO while the ALU keeps winning
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(i + 1); mem_data = 32'hD000_0000 + 32'(i + 1);
      set_alu(alu_idx);
      chk("fill_alu_ready", 32'(alu_ready), 32'd1);
      chk("fill_mem_ready", 32'(mem_ready), 32'd1);
      push_alu_exp();
      tick();
      alu_idx++;
    end
    chk("full_pend_cnt", 32'(pend_cnt), 32'd4);
    chk("full_mem_ready", 32'(mem_ready), 32'd0);
    chk("starved_alu_ready", 32'(alu_ready), 32'd0);

    // Drain under starvation: every fourth cycle the FIFO is forced to win
    for (int k = 0; k <= 12; k++) begin
      set_alu(alu_idx);
      if (k == 0) begin
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD;
      end else begin
        mem_valid = 1'b0;
      end
      if (k % 4 == 0) begin
        chk("drain_alu_ready_lo", 32'(alu_ready), 32'd0);
        push_exp(5'(k / 4 + 1), 32'hD000_0000 + 32'(k / 4 + 1), cyc + 1);
        tick();
      end else begin
        chk("drain_alu_ready_hi", 32'(alu_ready), 32'd1);
        push_alu_exp();
        tick();
        alu_idx++;
      end
      if (k == 0) begin
        chk("full_pop_pend_cnt", 32'(pend_cnt), 32'd3);
        chk("full_pop_mem_ready", 32'(mem_ready), 32'd1);
      end
    end
    chk("drained_pend_cnt", 32'(pend_cnt), 32'd0);
    set_alu(alu_idx);
    push_alu_exp();
    tick();
    alu_idx++;
    alu_valid = 1'b0;
    tick();

    // Stream ten memory results through the FIFO so the pointers wrap
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(i + 1); mem_data = 32'hE000_0000 + 32'(i);
      chk("wrap_mem_ready", 32'(mem_ready), 32'd1);
      push_exp(mem_rd, mem_data, cyc + 2);
      tick();
    end
    chk("wrap_pend_cnt", 32'(pend_cnt), 32'd1);
    mem_valid = 1'b0;
    tick();
    chk("wrap_empty", 32'(pend_cnt), 32'd0);
    tick();

    // Reset with three entries pending
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'hF000_0000 + 32'(i);
      set_alu(alu_idx);
      push_alu_exp();
      tick();
      alu_idx++;
    end
    chk("pre_rst_pend_cnt", 32'(pend_cnt), 32'd3);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
    chk("mid_rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("mid_rst_rf_wd", rf_wd, 32'd0);
    chk("mid_rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_rf_we", 32'(rf_we), 32'd0);
    end
    chk("post_rst_pend_cnt", 32'(pend_cnt), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
